// File: rtl/fml_bram_if.sv
// FML slave-side bus bundle: command, write-beat and read-beat signals.
// Pure wiring; no storage.
// The arbiter-side master holds fml_stb until it sees fml_eack.
interface fml_bram_if #(
    parameter int fml_depth = 26,
    parameter int fml_width = 32
);
    logic [fml_depth-1:0]   fml_adr;
    logic                   fml_stb;
    logic                   fml_we;
    logic                   fml_eack;
    logic [fml_width/8-1:0] fml_sel;
    logic [fml_width-1:0]   fml_di;
    logic [fml_width-1:0]   fml_do;

    modport master (
        output fml_adr, fml_stb, fml_we, fml_sel, fml_di,
        input  fml_eack, fml_do
    );

    modport slave (
        input  fml_adr, fml_stb, fml_we, fml_sel, fml_di,
        output fml_eack, fml_do
    );
endinterface

// File: rtl/fml_bram.sv
// Block-RAM responder serving aligned 4-beat FML bursts, one command at a time.
// Latency: eack same cycle as stb in IDLE; write beats E+1..E+4, read beats E+2..E+5.
// Backpressure: fml_stb is simply not acknowledged until the burst finishes (IDLE again at E+5).
module fml_bram #(
    parameter int fml_depth  = 26,
    parameter int fml_width  = 32,
    parameter int mem_awidth = 10
) (
    input  logic      sys_clk,
    input  logic      sys_rst,
    fml_bram_if.slave fml
);
    localparam int BW = fml_width / 8;
    localparam int B  = (BW > 1) ? $clog2(BW) : 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;

    logic [1:0]            state;
    logic [1:0]            k;
    logic [mem_awidth-3:0] base_q;
    logic [mem_awidth-1:0] mem_addr;
    logic [fml_width-1:0]  mem [0:(1<<mem_awidth)-1];
    logic [fml_width-1:0]  ram_q;
    logic                  rd_vld;
    logic                  accept;
    logic                  wr_en;
    logic                  rd_en;
    logic                  unused_adr;

    // Only the burst-base bits of the address are meaningful; the rest alias or are
    // ignored because bursts are always aligned.
    assign unused_adr = ^fml.fml_adr;

    // Reset overrides everything: no accepts, no writes, no read data while it is high.
    assign accept   = fml.fml_stb && (state == S_IDLE) && !sys_rst;
    assign wr_en    = (state == S_WRITE) && !sys_rst;
    assign rd_en    = (state == S_READ) && !sys_rst;
    assign mem_addr = {base_q, k};

    assign fml.fml_eack = accept;
    assign fml.fml_do   = (rd_vld && !sys_rst) ? ram_q : '0;

    // Command acceptance, beat counting and read-valid tracking.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state  <= S_IDLE;
            k      <= 2'd0;
            base_q <= '0;
            rd_vld <= 1'b0;
        end else begin
            rd_vld <= rd_en;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        base_q <= fml.fml_adr[B+2 +: mem_awidth-2];
                        k      <= 2'd0;
                        state  <= fml.fml_we ? S_WRITE : S_READ;
                    end
                end
                S_WRITE, S_READ: begin
                    k <= k + 2'd1;
                    if (k == 2'd3) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Byte-lane masked write port; lanes with sel low keep their old contents.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            for (int i = 0; i < BW; i++) begin
                if (fml.fml_sel[i]) begin
                    mem[mem_addr][i*8 +: 8] <= fml.fml_di[i*8 +: 8];
                end
            end
        end
    end

    // Synchronous read port; this register is the output stage, gated to zero by rd_vld.
    always_ff @(posedge sys_clk) begin
        if (rd_en) begin
            ram_q <= mem[mem_addr];
        end
    end
endmodule

// File: doc/fml_bram.md
# fml_bram

On-chip block-RAM responder for the FML memory bus. It sits on the slave side of the FML arbiter, in place of or alongside the SDRAM controller, and serves fixed 4-beat bursts. It accepts one command at a time, acknowledges it with a one-cycle early ack, and then transfers 4 write beats in or 4 read beats out with fixed timing. Typical use is a low-latency frame/line buffer for display or DSI masters.

## Interface

Parameters:
- fml_depth, 26, FML byte-address width.
- fml_width, 32, data width per beat; must be a multiple of 8.
- mem_awidth, 10, log2 of RAM depth in fml_width words; must be ≥ 2.

Ports:
- sys_clk  in  1  single clock; all logic is on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- fml_adr  in  fml_depth  byte address of the burst; sampled at accept.
- fml_stb  in  1  command request; held until fml_eack.
- fml_we  in  1  1 = write burst, 0 = read burst; sampled at accept.
- fml_eack  out  1  early ack; command accepted this cycle.
- fml_sel  in  fml_width/8  byte enables for the current write beat.
- fml_di  in  fml_width  write data for the current beat.
- fml_do  out  fml_width  read data for the current beat.

## Operation

- Word index: W = fml_adr[B +: mem_awidth], where B = log2(fml_width/8).
  - Burst base = {W[mem_awidth-1:2], 2'b00}.
  - Address bits above B+mem_awidth are ignored, so the RAM aliases across the address space.
  - W[1:0] is ignored; bursts are always aligned and sequential, with no wrap ordering.
- States: IDLE, WRITE, READ.
- IDLE:
  - fml_eack = fml_stb, combinationally.
  - When fml_stb = 1, the block latches the base address and fml_we, clears the beat counter k, and moves to WRITE or READ.
- WRITE: for k = 0..3, one beat per cycle.
  - Word base+k is written with fml_di, using byte lanes enabled by fml_sel.
  - A lane with sel = 0 leaves that byte unchanged.
  - After k = 3 the block returns to IDLE.
- READ: for k = 0..3, one beat per cycle.
  - The RAM is read at base+k through a synchronous read port.
  - The data is registered to fml_do.
  - After k = 3 the block returns to IDLE while the read pipeline drains.
- fml_do outside read beats: exactly 0.
- RAM: single array, one write port and one synchronous read port. Write-then-read of the same word in later bursts returns the new data.
- RAM contents are not cleared by reset. Reads of never-written words are undefined.

## Timing

Let E be the cycle in which fml_stb = 1 and fml_eack = 1.

- fml_eack is high for exactly one cycle per command and only in IDLE; it is never high in WRITE or READ.
- Write beats: fml_di/fml_sel are sampled at cycles E+1, E+2, E+3, E+4 for words base+0..3.
- Read beats: fml_do carries base+0..3 at cycles E+2, E+3, E+4, E+5.
- Command spacing: the block is back in IDLE at E+5, so the next fml_eack is possible at E+5. The minimum command-to-command interval is 5 cycles.
- A read accepted at E+5 after a write sees all 4 written words.
- Overlapping read data with a following write is legal. Read beats of burst 1 end at E+5 and write beats of burst 2 start at E+6, so there is no conflict.
- fml_stb already high when the block returns to IDLE: accepted in that same cycle, with no bubble.
- Reset values:
  - fml_eack = 0.
  - fml_do = 0.
  - state = IDLE.
  - k = 0.
  - The read pipeline valid flag is cleared.
- Reset mid-burst:
  - Remaining write beats are dropped; words already written are kept.
  - Remaining read beats are suppressed, so fml_do = 0 from the cycle after reset.
  - With fml_stb high, the first fml_eack after reset deasserts is in the first cycle that sys_rst = 0.

## Test plan

- **Basic write/read.** Write burst to adr 0x40 with data 0x11111111..0x44444444 and sel = 4'hF, then read 0x40.
  - Required: eack is one cycle each time.
  - Required: fml_do = 0x11111111, 0x22222222, 0x33333333, 0x44444444 at E+2..E+5; 0 at E+1 and E+6.
- **Byte enables.** Write 0xFFFFFFFF ×4 to 0x80, then write 0xAABBCCDD ×4 with sel = 4'b0101.
  - Required: readback of every word = 0xFFBBFFDD.
- **Alignment and aliasing.**
  - Read at 0x4C returns the same 4 words, in the same order, as 0x40.
  - With mem_awidth = 10, adr 0x1040 aliases 0x40.
- **Back-to-back commands.** Hold fml_stb high across write 0x100, read 0x100, write 0x200.
  - Required: eack at cycles E, E+5, E+10.
  - Required: the read returns the just-written data.
  - Required: fml_do beats never coincide with the next burst's write-beat window.
- **Reset mid-burst.** Write 0x300 with 0xA0..0xA3, asserting sys_rst at E+3 (after beat 1).
  - Required: word 0 = 0xA0, word 1 = 0xA1.
  - Required: words 2 and 3 keep their prior value.
  - Required: fml_eack = 0 and fml_do = 0 during reset.
  - Required: a new command is accepted in the first cycle after reset.
